// File: rtl/bl_pkg.sv
// rtl/bl_pkg.sv - shared constants and enums for the backlight frame scheduler
// Purpose: mode encodings, default LED count and FSM state enum.
// Ports: none (package).
package bl_pkg;

  localparam int BL_NUM_LEDS = 360;

  typedef enum logic [1:0] {
    MODE_VIDEO   = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_OFF     = 2'd3
  } bl_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bl_state_e;

endpackage

// File: rtl/bl_gray_calc.sv
// rtl/bl_gray_calc.sv - registered grayscale computation (pipeline stage 3)
// Purpose: scales a zone brightness by mode and global gain into a 16-bit gray value.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   i_en          load a new value; the output holds otherwise
//   i_mode        frame mode (bl_mode_e encoding)
//   i_bright      global brightness gain
//   i_zone        zone brightness
//   i_idx_lsb     LSB of the LED index (checker pattern)
//   i_parity      frame parity (checker inversion)
//   o_gray        registered grayscale result
module bl_gray_calc
  import bl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [7:0]        i_bright,
  input  logic [7:0]        i_zone,
  input  logic              i_idx_lsb,
  input  logic              i_parity,
  output logic [DATA_W-1:0] o_gray
);

  logic [DATA_W-1:0] w_full;
  logic [DATA_W-1:0] w_gray;
  logic [DATA_W-1:0] r_gray;

  assign w_full = DATA_W'(8'd255) * DATA_W'(i_bright);

  always_comb begin
    w_gray = '0;
    case (bl_mode_e'(i_mode))
      MODE_VIDEO:   w_gray = DATA_W'(i_zone) * DATA_W'(i_bright);
      MODE_SOLID:   w_gray = w_full;
      // Parity flips the pattern every frame so each LED alternates.
      MODE_CHECKER: w_gray = (i_idx_lsb ^ i_parity) ? '0 : w_full;
      default:      w_gray = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gray <= '0;
    end else if (i_en) begin
      r_gray <= w_gray;
    end
  end

  assign o_gray = r_gray;

endmodule

// File: rtl/bl_frame_scheduler.sv
// rtl/bl_frame_scheduler.sv - sequences one backlight frame into the LED SRAM write port
// Purpose: per frame request, walks all LED addresses, reads the zone buffer,
//          scales by mode/gain and emits one SRAM write per LED.
// Ports:
//   I_clk, I_rst        25 MHz LED clock, async active-high reset
//   I_frame_req         single-cycle frame start request
//   I_mode, I_bright    frame mode and global gain (latched at frame start)
//   O_zone_raddr        zone buffer read address
//   I_zone_rdata        zone brightness, one cycle after the address
//   O_sdbpflag          frame-start pulse to SRAM
//   O_wtvalid/O_wtaddr/O_wtdina  SRAM write strobe, address, data
//   O_busy              frame in progress
//   O_frame_done        pulse after the last write
//   O_overrun_cnt       dropped requests, saturating
module bl_frame_scheduler
  import bl_pkg::*;
#(
  parameter int NUM_LEDS = BL_NUM_LEDS,
  parameter int ADDR_W   = 10,
  parameter int ZADDR_W  = 9,
  parameter int DATA_W   = 16
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_frame_req,
  input  logic [1:0]         I_mode,
  input  logic [7:0]         I_bright,
  output logic [ZADDR_W-1:0] O_zone_raddr,
  input  logic [7:0]         I_zone_rdata,
  output logic               O_sdbpflag,
  output logic               O_wtvalid,
  output logic [ADDR_W-1:0]  O_wtaddr,
  output logic [DATA_W-1:0]  O_wtdina,
  output logic               O_busy,
  output logic               O_frame_done,
  output logic [7:0]         O_overrun_cnt
);

  bl_state_e          r_state;
  logic [ZADDR_W-1:0] r_idx;
  logic               r_drain;
  logic               r_pending;
  logic               r_parity;
  logic [1:0]         r_mode;
  logic [7:0]         r_bright;
  logic [7:0]         r_overrun;
  logic               r_sdbpflag;
  logic               r_frame_done;
  logic               r_s2_vld;
  logic [ADDR_W-1:0]  r_s2_idx;
  logic               r_wtvalid;
  logic [ADDR_W-1:0]  r_wtaddr;
  logic               w_busy;

  assign w_busy = (r_state != ST_IDLE);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_drain      <= 1'b0;
      r_pending    <= 1'b0;
      r_parity     <= 1'b0;
      r_mode       <= '0;
      r_bright     <= '0;
      r_overrun    <= '0;
      r_sdbpflag   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sdbpflag   <= 1'b0;
      r_frame_done <= 1'b0;
      // One request can be queued; anything beyond that is counted and dropped.
      if (I_frame_req && w_busy) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (r_overrun != 8'hFF) begin
          r_overrun <= r_overrun + 8'd1;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (I_frame_req || r_pending) begin
            r_state    <= ST_SOF;
            r_sdbpflag <= 1'b1;
            // A fresh request arriving together with a pending one stays queued.
            r_pending  <= r_pending & I_frame_req;
          end
        end
        ST_SOF: begin
          r_mode   <= I_mode;
          r_bright <= I_bright;
          r_idx    <= '0;
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          if (r_idx == ZADDR_W'(NUM_LEDS - 1)) begin
            r_state <= ST_DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain) begin
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        ST_DONE: begin
          r_parity <= ~r_parity;
          if (r_pending) begin
            r_state    <= ST_SOF;
            r_sdbpflag <= 1'b1;
            r_pending  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage 2: the zone buffer's registered read data arrives aligned with
  // these index/valid registers, so stage 3 sees rdata and index together.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_idx  <= '0;
      r_wtvalid <= 1'b0;
      r_wtaddr  <= '0;
    end else begin
      r_s2_vld  <= (r_state == ST_RUN);
      r_s2_idx  <= ADDR_W'(r_idx);
      r_wtvalid <= r_s2_vld;
      if (r_s2_vld) begin
        r_wtaddr <= r_s2_idx;
      end
    end
  end

  bl_gray_calc #(
    .DATA_W (DATA_W)
  ) u_gray (
    .i_clk     (I_clk),
    .i_rst     (I_rst),
    .i_en      (r_s2_vld),
    .i_mode    (r_mode),
    .i_bright  (r_bright),
    .i_zone    (I_zone_rdata),
    .i_idx_lsb (r_s2_idx[0]),
    .i_parity  (r_parity),
    .o_gray    (O_wtdina)
  );

  assign O_zone_raddr  = r_idx;
  assign O_sdbpflag    = r_sdbpflag;
  assign O_wtvalid     = r_wtvalid;
  assign O_wtaddr      = r_wtaddr;
  assign O_busy        = w_busy;
  assign O_frame_done  = r_frame_done;
  assign O_overrun_cnt = r_overrun;

endmodule

// File: tb/tb_bl_frame_scheduler.sv
// tb/tb_bl_frame_scheduler.sv - self-checking bench for bl_frame_scheduler
module tb_bl_frame_scheduler;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_frame_req = 1'b0;
  logic [1:0]  I_mode = 2'd0;
  logic [7:0]  I_bright = 8'd0;
  logic [8:0]  O_zone_raddr;
  logic [7:0]  I_zone_rdata;
  logic        O_sdbpflag;
  logic        O_wtvalid;
  logic [9:0]  O_wtaddr;
  logic [15:0] O_wtdina;
  logic        O_busy;
  logic        O_frame_done;
  logic [7:0]  O_overrun_cnt;

  bl_frame_scheduler dut (
    .I_clk         (I_clk),
    .I_rst         (I_rst),
    .I_frame_req   (I_frame_req),
    .I_mode        (I_mode),
    .I_bright      (I_bright),
    .O_zone_raddr  (O_zone_raddr),
    .I_zone_rdata  (I_zone_rdata),
    .O_sdbpflag    (O_sdbpflag),
    .O_wtvalid     (O_wtvalid),
    .O_wtaddr      (O_wtaddr),
    .O_wtdina      (O_wtdina),
    .O_busy        (O_busy),
    .O_frame_done  (O_frame_done),
    .O_overrun_cnt (O_overrun_cnt)
  );

  always #20 I_clk = ~I_clk;

  // Zone buffer with one cycle of read latency; zone[i] = i mod 256.
  logic [7:0] zmem [512];
  initial for (int i = 0; i < 512; i++) zmem[i] = 8'(i % 256);
  always @(posedge I_clk) I_zone_rdata <= zmem[O_zone_raddr];

  int edge_n = 0;
  always @(posedge I_clk) edge_n <= edge_n + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int t;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  sofq[$];
  int  doneq[$];
  int  cap[360];
  int  wr_cnt = 0;

  // Reference model state
  int m_cur  = -10000;
  bit m_pend = 0;
  bit m_par  = 0;
  int m_ovr  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_gray(input int mode, input int bright, input int i, input int par);
    case (mode)
      0: return (i % 256) * bright;
      1: return 255 * bright;
      2: return ((((i % 2) ^ par) == 0) ? 255 * bright : 0);
      default: return 0;
    endcase
  endfunction

  task automatic push_frame(input int s);
    sofq.push_back(s);
    for (int i = 0; i < 360; i++)
      wq.push_back('{t: s + 3 + i, addr: i, data: exp_gray(int'(I_mode), int'(I_bright), i, int'(m_par))});
    doneq.push_back(s + 363);
    m_par = ~m_par;
  endtask

  // e = number of the clock edge that samples the request.
  task automatic model_req(input int e);
    if (m_pend && e > m_cur + 364) begin
      m_cur  = m_cur + 364;
      m_pend = 0;
    end
    if (e > m_cur + 364) begin
      m_cur = e;
      push_frame(e);
    end else if (!m_pend) begin
      m_pend = 1;
      push_frame(m_cur + 364);
    end else if (m_ovr < 255) begin
      m_ovr++;
    end
  endtask

  task automatic model_reset();
    wq.delete();
    sofq.delete();
    doneq.delete();
    m_cur  = -10000;
    m_pend = 0;
    m_par  = 0;
    m_ovr  = 0;
  endtask

  wr_t x;
  int  t_exp;
  always @(negedge I_clk) begin
    if (O_wtvalid) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", int'(O_wtaddr), -1);
      end else begin
        x = wq.pop_front();
        n_vec++;
        if (int'(O_wtaddr) != x.addr || int'(O_wtdina) != x.data || edge_n != x.t) begin
          n_err++;
          $display("FAIL write: addr %0d data %0d t %0d, expected addr %0d data %0d t %0d",
                   O_wtaddr, O_wtdina, edge_n, x.addr, x.data, x.t);
        end
      end
      if (O_wtaddr < 10'd360) cap[O_wtaddr] = int'(O_wtdina);
      wr_cnt++;
    end
    if (O_sdbpflag) begin
      t_exp = (sofq.size() != 0) ? sofq.pop_front() : -1;
      chk("sdbpflag_time", edge_n, t_exp);
      wr_cnt = 0;
    end
    if (O_frame_done) begin
      t_exp = (doneq.size() != 0) ? doneq.pop_front() : -1;
      chk("frame_done_time", edge_n, t_exp);
    end
  end

  task automatic pulse_req();
    @(negedge I_clk);
    I_frame_req = 1'b1;
    model_req(edge_n + 1);
    @(negedge I_clk);
    I_frame_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge I_clk);
      if (!O_busy && wq.size() == 0 && sofq.size() == 0 && doneq.size() == 0) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_write(input int addr);
    bit hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge I_clk);
      if (O_wtvalid && int'(O_wtaddr) == addr) hit = 1;
    end
    if (!hit) chk("write_wait_timeout", 0, 1);
  endtask

  function automatic int outs_nonzero();
    return int'(O_sdbpflag) + int'(O_wtvalid) + int'(O_wtaddr != 0) + int'(O_wtdina != 0) +
           int'(O_busy) + int'(O_frame_done) + int'(O_overrun_cnt != 0) + int'(O_zone_raddr != 0);
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic [7:0] bright;
    int         idx;
    int         exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int bad;
    // Frames run in order, so checker parity is known: frame n has parity n%2.
    tbl[0] = '{mode: 2'd0, bright: 8'd128, idx: 5,   exp: 640};
    tbl[1] = '{mode: 2'd0, bright: 8'd128, idx: 300, exp: 5632};
    tbl[2] = '{mode: 2'd1, bright: 8'd200, idx: 7,   exp: 51000};
    tbl[3] = '{mode: 2'd2, bright: 8'd255, idx: 1,   exp: 65025};
    tbl[4] = '{mode: 2'd2, bright: 8'd255, idx: 1,   exp: 0};
    tbl[5] = '{mode: 2'd3, bright: 8'd255, idx: 10,  exp: 0};
    tbl[6] = '{mode: 2'd0, bright: 8'd255, idx: 255, exp: 65025};
    tbl[7] = '{mode: 2'd0, bright: 8'd0,   idx: 100, exp: 0};

    repeat (3) @(negedge I_clk);
    chk("reset_outputs", outs_nonzero(), 0);
    I_rst = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge I_clk);
      if (outs_nonzero() != 0) bad++;
    end
    chk("idle_1000_cycles", bad, 0);
    chk("overrun_after_reset", int'(O_overrun_cnt), 0);

    for (int v = 0; v < 8; v++) begin
      I_mode   = tbl[v].mode;
      I_bright = tbl[v].bright;
      pulse_req();
      wait_idle(1000);
      chk("frame_write_count", wr_cnt, 360);
      chk($sformatf("table_vec%0d", v), cap[tbl[v].idx], tbl[v].exp);
    end

    // Checker back-to-back: second request queued, frame 2 inverted.
    I_mode   = 2'd2;
    I_bright = 8'd255;
    pulse_req();
    repeat (10) @(negedge I_clk);
    pulse_req();
    wait_idle(2000);
    chk("checker2_idx0", cap[0], 0);
    chk("checker2_idx1", cap[1], 65025);

    // Three requests during one frame: one queued, two dropped.
    I_mode   = 2'd0;
    I_bright = 8'd1;
    pulse_req();
    repeat (20) @(negedge I_clk);
    repeat (3) begin
      pulse_req();
      repeat (5) @(negedge I_clk);
    end
    wait_idle(2000);
    chk("overrun_two", int'(O_overrun_cnt), 2);

    repeat (300) pulse_req();
    wait_idle(3000);
    chk("overrun_model", int'(O_overrun_cnt), m_ovr);
    chk("overrun_saturate", int'(O_overrun_cnt), 255);

    // Mid-frame mode/gain change must not affect the running frame.
    I_mode   = 2'd0;
    I_bright = 8'd128;
    pulse_req();
    wait_write(100);
    I_mode   = 2'd3;
    I_bright = 8'd7;
    wait_idle(1000);
    chk("shadow_idx300", cap[300], 5632);
    chk("shadow_write_count", wr_cnt, 360);

    // Async reset at write 200, then a clean full frame.
    I_mode   = 2'd0;
    I_bright = 8'd128;
    pulse_req();
    wait_write(200);
    #2;
    I_rst = 1'b1;
    model_reset();
    #1;
    chk("async_reset_outputs", outs_nonzero(), 0);
    repeat (3) @(negedge I_clk);
    I_rst = 1'b0;
    repeat (50) @(negedge I_clk);
    chk("no_writes_after_reset", wr_cnt, 200 + 1);
    pulse_req();
    wait_idle(1000);
    chk("post_reset_write_count", wr_cnt, 360);
    chk("post_reset_idx0", cap[0], 0);
    chk("post_reset_idx5", cap[5], 640);
    chk("post_reset_overrun", int'(O_overrun_cnt), 0);

    chk("leftover_writes", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
